// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word array with byte/halfword/word access and little-endian lanes.
// Latency WAIT_STATES stall cycles plus one ready cycle per OKAY transfer; ERROR takes two cycles.
// Backpressure: HREADYOUT low during wait states and ERR1; new requests are taken only while HREADY is high.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic [1:0]            HRESP,
    output logic                  HREADYOUT
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q;
    logic [3:0]        be_q, be_d;
    logic              wr_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic can_take, take, illegal, out_of_range;
    logic unused_htrans;

    assign unused_htrans = HTRANS[0];

    assign can_take     = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    assign take         = can_take && HSEL && HREADY && HTRANS[1];
    assign out_of_range = {2'b00, HADDR[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(MEM_DEPTH);
    assign illegal      = (HSIZE > 3'b010)
                       || ((HSIZE == 3'b001) && HADDR[0])
                       || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00))
                       || out_of_range;

    always_comb begin
        be_d = 4'b1111;
        case (HSIZE[1:0])
            2'b00:   be_d = 4'b0001 << HADDR[1:0];
            2'b01:   be_d = HADDR[1] ? 4'b1100 : 4'b0011;
            default: be_d = 4'b1111;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                if (take) begin
                    if (illegal) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            be_q    <= 4'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take) begin
                idx_q <= HADDR[IDX_W+1:2];
                be_q  <= be_d;
                wr_q  <= HWRITE;
            end
        end
    end

    // Array is not reset; an asynchronous reset forces IDLE so a pending write never commits.
    always_ff @(posedge HCLK) begin
        if ((state_q == ST_DATA) && wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign HREADYOUT = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
    assign HRDATA    = ((state_q == ST_DATA) && !wr_q) ? mem[idx_q] : '0;

endmodule
